// File: rtl/ctr_burst_pkg.sv
// Shared types for the counter burst sequencer: FSM states, default widths
// and the latched burst configuration.
package ctr_burst_pkg;

    localparam int CTR_WIDTH = 8;
    localparam int CTR_LEN_W = 8;
    localparam int CTR_REP_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [CTR_WIDTH-1:0] start_val;
        logic [CTR_LEN_W-1:0] run_len;
        logic [CTR_LEN_W-1:0] gap_len;
        logic [CTR_REP_W-1:0] repeat_cnt;
    } cfg_t;

    // True when idx is the final burst of a sequence of rep bursts.
    function automatic logic is_last(input logic [CTR_REP_W-1:0] idx,
                                     input logic [CTR_REP_W-1:0] rep);
        return idx == (rep - CTR_REP_W'(1));
    endfunction

endpackage

// File: rtl/ctr_burst_timer.sv
// Loadable down-counter with terminal-count flag; times both RUN and GAP
// phases of the burst sequencer.
module ctr_burst_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Load has priority; the count parks at zero once the phase has expired.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= W'(0);
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && !tc) begin
            count_r <= count_r - W'(1);
        end
    end

    assign tc = (count_r == W'(0));

endmodule

// File: rtl/ctr_burst_sequencer.sv
// Burst sequencer driving an 8-bit loadable up-counter: one load, then
// repeat_cnt bursts of run_len enables separated by gap_len idle cycles.
// Define CTR_BURST_COUNT_CHECK_EN to add the err output and count checker.
module ctr_burst_sequencer
    import ctr_burst_pkg::*;
#(
    parameter int WIDTH = CTR_WIDTH,
    parameter int LEN_W = CTR_LEN_W,
    parameter int REP_W = CTR_REP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [LEN_W-1:0] run_len,
    input  logic [LEN_W-1:0] gap_len,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic             abort,
    input  logic [WIDTH-1:0] ctr_cout,
    output logic             ctr_load,
    output logic             ctr_enable,
    output logic [WIDTH-1:0] ctr_data,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] burst_idx
`ifdef CTR_BURST_COUNT_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    state_t           state_r;
    cfg_t             cfg_r;
    logic             tmr_load_s;
    logic             tmr_dec_s;
    logic             tmr_tc_s;
    logic [LEN_W-1:0] tmr_val_s;
    logic             last_s;
    logic             next_last_s;

    assign last_s      = is_last(burst_idx, cfg_r.repeat_cnt);
    assign next_last_s = is_last(burst_idx + REP_ONE, cfg_r.repeat_cnt);
    assign ctr_data    = cfg_r.start_val;

    ctr_burst_timer #(.W(LEN_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .dec      (tmr_dec_s),
        .tc       (tmr_tc_s)
    );

    // Timer arms the length of whichever phase the FSM enters next.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        tmr_val_s  = cfg_r.run_len - LEN_ONE;
        case (state_r)
            LOAD: begin
                tmr_load_s = 1'b1;
                if (cfg_r.run_len == LEN_ZERO) begin
                    tmr_val_s = cfg_r.gap_len - LEN_ONE;
                end else begin
                    tmr_val_s = cfg_r.run_len - LEN_ONE;
                end
            end
            RUN: begin
                if (tmr_tc_s) begin
                    tmr_load_s = 1'b1;
                    if (cfg_r.gap_len != LEN_ZERO) begin
                        tmr_val_s = cfg_r.gap_len - LEN_ONE;
                    end else begin
                        tmr_val_s = cfg_r.run_len - LEN_ONE;
                    end
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            GAP: begin
                if (tmr_tc_s) begin
                    tmr_load_s = 1'b1;
                    if (cfg_r.run_len != LEN_ZERO) begin
                        tmr_val_s = cfg_r.run_len - LEN_ONE;
                    end else begin
                        tmr_val_s = cfg_r.gap_len - LEN_ONE;
                    end
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
                tmr_dec_s  = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered counter controls and handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            cfg_r      <= '0;
            ctr_load   <= 1'b0;
            ctr_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            burst_idx  <= REP_ZERO;
        end else if (abort && (state_r != IDLE)) begin
            state_r    <= IDLE;
            ctr_load   <= 1'b0;
            ctr_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ctr_load   <= 1'b0;
                    ctr_enable <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        cfg_r     <= {start_val, run_len, gap_len, repeat_cnt};
                        state_r   <= LOAD;
                        ctr_load  <= 1'b1;
                        busy      <= 1'b1;
                        burst_idx <= REP_ZERO;
                    end
                end
                LOAD: begin
                    ctr_load <= 1'b0;
                    // Empty bursts only walk the gaps; with no gaps either there is nothing to time.
                    if ((cfg_r.repeat_cnt == REP_ZERO) ||
                        ((cfg_r.run_len == LEN_ZERO) &&
                         ((cfg_r.repeat_cnt == REP_ONE) || (cfg_r.gap_len == LEN_ZERO)))) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (cfg_r.run_len == LEN_ZERO) begin
                        state_r <= GAP;
                    end else begin
                        state_r    <= RUN;
                        ctr_enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (tmr_tc_s) begin
                        if (last_s) begin
                            state_r    <= DONE;
                            ctr_enable <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else if (cfg_r.gap_len != LEN_ZERO) begin
                            state_r    <= GAP;
                            ctr_enable <= 1'b0;
                        end else begin
                            burst_idx <= burst_idx + REP_ONE;
                        end
                    end
                end
                GAP: begin
                    if (tmr_tc_s) begin
                        burst_idx <= burst_idx + REP_ONE;
                        if (cfg_r.run_len != LEN_ZERO) begin
                            state_r    <= RUN;
                            ctr_enable <= 1'b1;
                        end else if (next_last_s) begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    ctr_load   <= 1'b0;
                    ctr_enable <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

`ifdef CTR_BURST_COUNT_CHECK_EN
    logic [WIDTH-1:0] exp_r;
    logic             check_s;

    assign check_s = (state_r == RUN) || (state_r == GAP) || (state_r == DONE);

    // Shadow of the counter; any divergence while checking latches err.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exp_r <= WIDTH'(0);
            err   <= 1'b0;
        end else begin
            if (state_r == LOAD) begin
                exp_r <= cfg_r.start_val;
            end else if (ctr_enable) begin
                exp_r <= exp_r + WIDTH'(1);
            end
            if ((state_r == IDLE) && start) begin
                err <= 1'b0;
            end else if (check_s && (ctr_cout != exp_r)) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_s;
    assign unused_s = ^ctr_cout;
`endif

endmodule

// File: tb/tb_ctr_burst_sequencer.sv
// Self-checking bench for ctr_burst_sequencer: a behavioural counter stands in
// for the counter instance; a scoreboard checks each sequence at its done pulse.
module tb_ctr_burst_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] start_val = 8'h00;
    logic [7:0] run_len = 8'h00;
    logic [7:0] gap_len = 8'h00;
    logic [3:0] repeat_cnt = 4'h0;
    logic [7:0] ctr_cout;
    logic       ctr_load;
    logic       ctr_enable;
    logic [7:0] ctr_data;
    logic       busy;
    logic       done;
    logic [3:0] burst_idx;
`ifdef CTR_BURST_COUNT_CHECK_EN
    logic       err;
`endif

    always #5 clk = ~clk;

    ctr_burst_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_val  (start_val),
        .run_len    (run_len),
        .gap_len    (gap_len),
        .repeat_cnt (repeat_cnt),
        .abort      (abort),
        .ctr_cout   (ctr_cout),
        .ctr_load   (ctr_load),
        .ctr_enable (ctr_enable),
        .ctr_data   (ctr_data),
        .busy       (busy),
        .done       (done),
        .burst_idx  (burst_idx)
`ifdef CTR_BURST_COUNT_CHECK_EN
        ,
        .err        (err)
`endif
    );

    // Behavioural counter; stuck forces its visible output to a fixed value.
    logic [7:0] ctr_q;
    logic       stuck = 1'b0;
    logic [7:0] stuck_val = 8'h00;
    always @(posedge clk) begin
        if (!reset)          ctr_q <= 8'h00;
        else if (ctr_load)   ctr_q <= ctr_data;
        else if (ctr_enable) ctr_q <= ctr_q + 8'd1;
    end
    assign ctr_cout = stuck ? stuck_val : ctr_q;

    typedef struct {
        logic [7:0] sv;
        logic [7:0] rl;
        logic [7:0] gl;
        logic [3:0] rc;
        logic [7:0] cout;
    } vec_t;

    typedef struct {
        logic [7:0] cout;
        int         ens;
        int         cycles;
        int         run;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input vec_t v, input logic err_exp);
        exp_t e;
        e.cout   = v.cout;
        e.ens    = int'(v.rc) * int'(v.rl);
        e.cycles = 2 + e.ens + ((v.rc > 4'd0) ? (int'(v.rc) - 1) * int'(v.gl) : 0);
        e.run    = int'(v.rl);
        e.err    = err_exp;
        sb_q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input bit push, input logic err_exp);
        start_val  = v.sv;
        run_len    = v.rl;
        gap_len    = v.gl;
        repeat_cnt = v.rc;
        start      = 1'b1;
        if (push) push_exp(v, err_exp);
        @(negedge clk);
        start      = 1'b0;
        start_val  = 8'($urandom);
        run_len    = 8'($urandom);
        gap_len    = 8'($urandom);
        repeat_cnt = 4'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && sb_q.size() > 0; i++) @(negedge clk);
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: measures each sequence from busy rising and scores it at done.
    int   m_cyc = 0;
    int   m_loads = 0;
    int   m_ens = 0;
    logic busy_d = 1'b0;
    exp_t m_e;
    always @(negedge clk) begin
        if (busy && !busy_d) begin
            m_cyc = 0;
            m_loads = 0;
            m_ens = 0;
        end
        m_cyc++;
        if (ctr_load) m_loads++;
        if (ctr_enable) begin
            if (sb_q.size() > 0 && sb_q[0].run > 0)
                check("burst_idx", 32'(burst_idx), 32'(m_ens / sb_q[0].run));
            m_ens++;
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                m_e = sb_q.pop_front();
                check("final_cout", 32'(ctr_cout), 32'(m_e.cout));
                check("enable_cycles", 32'(m_ens), 32'(m_e.ens));
                check("start_to_done", 32'(m_cyc), 32'(m_e.cycles));
                check("load_count", 32'(m_loads), 32'd1);
                check("busy_at_done", 32'(busy), 32'd0);
`ifdef CTR_BURST_COUNT_CHECK_EN
                check("err_at_done", 32'(err), 32'(m_e.err));
`endif
            end
        end
        busy_d = busy;
    end

    vec_t vecs[8];
    logic found;
    int   cnt;

    initial begin
        vecs[0] = '{8'hFF, 8'd5,   8'd1, 4'd5,  8'h18};
        vecs[1] = '{8'h3C, 8'd7,   8'd2, 4'd0,  8'h3C};
        vecs[2] = '{8'h10, 8'd4,   8'd0, 4'd3,  8'h1C};
        vecs[3] = '{8'h00, 8'd1,   8'd3, 4'd2,  8'h02};
        vecs[4] = '{8'h80, 8'd0,   8'd2, 4'd3,  8'h80};
        vecs[5] = '{8'hF0, 8'd255, 8'd0, 4'd1,  8'hEF};
        vecs[6] = '{8'h7F, 8'd3,   8'd2, 4'd15, 8'hAC};
        vecs[7] = '{8'h01, 8'd2,   8'd1, 4'd1,  8'h03};

        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({ctr_load, ctr_enable, ctr_data, busy, done, burst_idx}), 32'd0);
`ifdef CTR_BURST_COUNT_CHECK_EN
        check("reset_err", 32'(err), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_vec(vecs[i], 1'b1, 1'b0);
            drain();
        end

        // A start raised during the DONE cycle is taken one cycle later, not in DONE.
        run_vec('{8'h10, 8'd2, 8'd1, 4'd2, 8'h14}, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = done;
        end
        check("done_seen", 32'(found), 32'd1);
        start_val = 8'h40; run_len = 8'd3; gap_len = 8'd0; repeat_cnt = 4'd1;
        start = 1'b1;
        push_exp('{8'h40, 8'd3, 8'd0, 4'd1, 8'h43}, 1'b0);
        @(negedge clk);
        check("start_in_done_ignored", 32'({busy, ctr_load}), 32'd0);
        @(negedge clk);
        check("start_in_idle_taken", 32'({busy, ctr_load}), 32'd3);
        start = 1'b0;
        drain();

        // start while busy is ignored; reset mid-GAP clears everything without done.
        run_vec('{8'h10, 8'd3, 8'd4, 4'd3, 8'h19}, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_while_busy", 32'({ctr_load, ctr_enable}), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = busy && !ctr_enable;
        end
        check("reach_gap", 32'(found), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_gap", 32'({ctr_load, ctr_enable, ctr_data, busy, done, burst_idx}), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("no_restart_after_reset", 32'({busy, done}), 32'd0);

        // abort on the 3rd RUN cycle of burst 1, then start together with abort.
        run_vec('{8'h20, 8'd5, 8'd2, 4'd3, 8'h2F}, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 3; i++) begin
            @(negedge clk);
            if (ctr_enable && burst_idx == 4'd1) cnt++;
        end
        check("abort_reach", 32'(cnt), 32'd3);
        abort = 1'b1;
        @(negedge clk);
        check("abort_outputs", 32'({busy, ctr_enable, ctr_load, done}), 32'd0);
        run_vec('{8'h05, 8'd2, 8'd1, 4'd2, 8'h09}, 1'b1, 1'b0);
        abort = 1'b0;
        check("start_beats_abort", 32'({busy, ctr_load}), 32'd3);
        drain();

`ifdef CTR_BURST_COUNT_CHECK_EN
        run_vec('{8'h00, 8'd6, 8'd2, 4'd2, 8'h0C}, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = ctr_enable;
        end
        check("err_reach_run", 32'(found), 32'd1);
        stuck_val = 8'hA5;
        stuck = 1'b1;
        @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        stuck = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = done;
        end
        check("err_sticky_done", 32'({found, err}), 32'd3);
        @(negedge clk);
        run_vec('{8'h01, 8'd1, 8'd0, 4'd1, 8'h02}, 1'b1, 1'b0);
        check("err_clear_on_start", 32'(err), 32'd0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ctr_burst_sequencer.md
Name: ctr_burst_sequencer

Overview:
- Controller that sequences the 8-bit loadable up-counter (vhdl_dut) by driving its load, enable and data inputs.
- Runs a programmed burst pattern: one load of a start value, then `repeat_cnt` bursts of `run_len` enabled cycles, separated by `gap_len` idle cycles.
- Sits between a test/control master, which uses a start/busy/done handshake, and the counter instance.

Parameters:
- WIDTH, 8, counter data/cout width
- LEN_W, 8, width of run_len and gap_len
- REP_W, 4, width of repeat_cnt

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- start  in  1  request to begin a sequence; sampled only in IDLE
- start_val  in  WIDTH  value loaded into the counter
- run_len  in  LEN_W  enabled cycles per burst
- gap_len  in  LEN_W  idle cycles between bursts
- repeat_cnt  in  REP_W  number of bursts
- abort  in  1  terminate the sequence immediately
- ctr_cout  in  WIDTH  counter output, used by the optional check
- ctr_load  out  1  counter load strobe
- ctr_enable  out  1  counter count enable
- ctr_data  out  WIDTH  counter load data
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- burst_idx  out  REP_W  index of the current burst, 0-based

Behaviour:
- Reset (reset=0 at a clk edge):
  - Outputs: ctr_load=0, ctr_enable=0, ctr_data=0, busy=0, done=0, burst_idx=0.
  - State: FSM goes to IDLE; all internal counters are cleared.
  - Reset mid-sequence abandons the sequence with no done pulse.
- FSM states: IDLE, LOAD, RUN, GAP, DONE. All outputs are registered.
- IDLE:
  - start=1 latches start_val, run_len, gap_len and repeat_cnt, then moves to LOAD.
  - busy rises on the same edge.
- LOAD: lasts exactly 1 cycle, with ctr_load=1 and ctr_data=start_val.
  - repeat_cnt=0: go to DONE.
  - else if run_len=0: treat each burst as empty; step through the GAPs only and finish at DONE.
  - else: go to RUN.
- RUN:
  - ctr_enable=1 for exactly run_len consecutive cycles.
  - Last cycle of the last burst: go to DONE, with no trailing GAP.
  - Otherwise: go to GAP.
- GAP:
  - ctr_enable=0 for exactly gap_len cycles.
  - gap_len=0 means zero GAP cycles: RUN goes directly to the next RUN, but the burst boundary still increments burst_idx.
  - On exit, burst_idx increments and the FSM returns to RUN.
- DONE: lasts 1 cycle, with done=1 and busy=0, then goes to IDLE.
  - A start arriving in the DONE cycle is ignored.
  - A start in the following cycle (IDLE) is accepted.
- Only one load per sequence: the counter accumulates across bursts and is not reloaded.
- The counter wraps modulo 2^WIDTH; the sequencer does not intervene.
- Total count increment = repeat_cnt*run_len mod 2^WIDTH.
- start while busy=1 is ignored. Config inputs are don't-care outside the IDLE sampling cycle.
- abort:
  - abort=1 in any non-IDLE state goes to IDLE on the next edge: ctr_enable=0, ctr_load=0, busy=0, no done pulse.
  - abort has priority over all other transitions. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins; abort applies only from the next cycle.
- Latency: start edge to first ctr_load=1 is 1 cycle; to first ctr_enable=1 is 2 cycles.

Optional Feature:
- Macro: CTR_BURST_COUNT_CHECK_EN.
- With the macro defined:
  - Adds output `err` (1 bit, reset 0) and an internal expected-count register `exp`.
  - exp mirrors the counter: it loads start_val on the LOAD edge and increments modulo 2^WIDTH on each ctr_enable edge.
  - From the cycle after LOAD until DONE, ctr_cout!=exp sets err.
  - err is sticky until the next accepted start or reset. Abort stops checking but keeps err.
- Without the macro: no err port, no exp register, and ctr_cout is unused.

Decomposition:
- Package ctr_burst_pkg holds:
  - state enum typedef (IDLE, LOAD, RUN, GAP, DONE);
  - WIDTH/LEN_W/REP_W default localparams;
  - a config struct {start_val, run_len, gap_len, repeat_cnt}.
- One natural sub-module: ctr_burst_timer, a loadable down-counter with a terminal-count flag, shared by the RUN and GAP phases.

Test Plan:
- start_val=8'hFF, run_len=5, gap_len=1, repeat_cnt=5 -> one load; five 5-cycle enable bursts with 1-cycle gaps; done pulse; final ctr_cout=8'h18 (wrap through 00).
- repeat_cnt=0 with start_val=8'h3C -> a single ctr_load cycle, then done one cycle later; ctr_enable never asserts; ctr_cout=8'h3C.
- run_len=4, gap_len=0, repeat_cnt=3 -> 12 contiguous enable cycles; burst_idx steps 0,1,2; ctr_cout=start_val+12.
- abort asserted on the 3rd RUN cycle of burst 1 -> next cycle busy=0 and ctr_enable=0, no done pulse; a new start is accepted 1 cycle later.
- reset=0 held for 1 cycle mid-GAP, plus start pulsed while busy -> all outputs are 0 after the edge; the start while busy is ignored (no restart until IDLE).
- CTR_BURST_COUNT_CHECK_EN: force ctr_cout to a stuck value during RUN -> err=1 within 1 cycle, stays 1 through DONE, and clears on the next start.
